// File: rtl/prog_load_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_load_pkg                                                         |
// | Shared types and constants for the program-load controller.          |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package prog_load_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_LO   = 3'd2,
      ST_HI   = 3'd3,
      ST_CHK  = 3'd4,
      ST_DONE = 3'd5,
      ST_RUN  = 3'd6,
      ST_ERR  = 3'd7
   } state_e;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT  = 8'hA5;
   localparam int unsigned LEN_ZERO_MEANS_MAX = 256;

   // Bits needed to hold a gap count of 0..cycles.
   function automatic int unsigned timeout_width(input int unsigned cycles);
      int unsigned w;
      w = $clog2(cycles + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prog_load_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_load_timeout                                                     |
// | Idle-gap watchdog: o_expired flags the LIMIT-th consecutive idle cycle.|
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module prog_load_timeout
   import prog_load_pkg::*;
#(
   parameter int unsigned LIMIT = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned   CW   = timeout_width(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      o_expired = i_enable && !i_clear && (count_q == LAST);
      count_d   = count_q;
      if (i_clear || !i_enable) begin
         count_d = '0;
      end else if (!o_expired) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/prog_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_load_ctrl                                                        |
// | Parses UART load frames into program-memory writes; holds the CPU in  |
// | reset until a full program is loaded. Optional checksum byte when     |
// | PROG_LOAD_CHECKSUM_EN is defined.                                     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module prog_load_ctrl
   import prog_load_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned CMD_WIDTH      = 12,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic                  prog_write,
   output logic [ADDR_WIDTH-1:0] prog_address,
   output logic [CMD_WIDTH-1:0]  prog_cmd,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  load_error
);

   state_e                state_q, state_d;
   logic [8:0]            rem_q, rem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            lo_q, lo_d;
   logic                  prog_write_q, prog_write_d;
   logic [ADDR_WIDTH-1:0] prog_address_q, prog_address_d;
   logic [CMD_WIDTH-1:0]  prog_cmd_q, prog_cmd_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  load_done_q, load_done_d;
   logic                  load_error_q, load_error_d;
`ifdef PROG_LOAD_CHECKSUM_EN
   logic [7:0]            chk_q, chk_d;
`endif

   logic w_in_frame;
   logic w_expired;
   logic w_is_sync;

   assign w_in_frame = (state_q == ST_LEN) || (state_q == ST_LO) ||
                       (state_q == ST_HI)  || (state_q == ST_CHK);
   assign w_is_sync  = rx_valid && (rx_byte == SYNC_BYTE);

   prog_load_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (rx_valid),
      .i_enable  (w_in_frame),
      .o_expired (w_expired)
   );

   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      addr_d         = addr_q;
      lo_d           = lo_q;
      prog_write_d   = 1'b0;
      prog_address_d = prog_address_q;
      prog_cmd_d     = prog_cmd_q;
`ifdef PROG_LOAD_CHECKSUM_EN
      chk_d          = chk_q;
`endif
      case (state_q)
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (w_is_sync) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (rx_valid) begin
               rem_d   = (rx_byte == 8'd0) ? 9'(LEN_ZERO_MEANS_MAX) : {1'b0, rx_byte};
               addr_d  = '0;
               state_d = ST_LO;
`ifdef PROG_LOAD_CHECKSUM_EN
               chk_d   = 8'd0;
`endif
            end
         end
         ST_LO: begin
            if (rx_valid) begin
               lo_d    = rx_byte;
               state_d = ST_HI;
`ifdef PROG_LOAD_CHECKSUM_EN
               chk_d   = chk_q ^ rx_byte;
`endif
            end
         end
         ST_HI: begin
            if (rx_valid) begin
               prog_write_d   = 1'b1;
               prog_address_d = addr_q;
               prog_cmd_d     = {rx_byte[CMD_WIDTH-9:0], lo_q};
               addr_d         = addr_q + ADDR_WIDTH'(1);
               rem_d          = rem_q - 9'd1;
`ifdef PROG_LOAD_CHECKSUM_EN
               chk_d          = chk_q ^ rx_byte;
               state_d        = (rem_q == 9'd1) ? ST_CHK : ST_LO;
`else
               state_d        = (rem_q == 9'd1) ? ST_DONE : ST_LO;
`endif
            end
         end
`ifdef PROG_LOAD_CHECKSUM_EN
         ST_CHK: begin
            if (rx_valid) state_d = (rx_byte == chk_q) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE: state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase

      // Only asserts on an idle cycle inside a frame, so it never races a byte.
      if (w_expired) state_d = ST_ERR;

      cpu_reset_d  = (state_d != ST_RUN);
      load_done_d  = (state_d == ST_DONE);
      load_error_d = load_error_q;
      if (state_d == ST_ERR) begin
         load_error_d = 1'b1;
      end else if (state_d == ST_DONE) begin
         load_error_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rem_q          <= 9'd0;
         addr_q         <= '0;
         lo_q           <= 8'd0;
         prog_write_q   <= 1'b0;
         prog_address_q <= '0;
         prog_cmd_q     <= '0;
         cpu_reset_q    <= 1'b1;
         load_done_q    <= 1'b0;
         load_error_q   <= 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
         chk_q          <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         rem_q          <= rem_d;
         addr_q         <= addr_d;
         lo_q           <= lo_d;
         prog_write_q   <= prog_write_d;
         prog_address_q <= prog_address_d;
         prog_cmd_q     <= prog_cmd_d;
         cpu_reset_q    <= cpu_reset_d;
         load_done_q    <= load_done_d;
         load_error_q   <= load_error_d;
`ifdef PROG_LOAD_CHECKSUM_EN
         chk_q          <= chk_d;
`endif
      end
   end

   assign prog_write   = prog_write_q;
   assign prog_address = prog_address_q;
   assign prog_cmd     = prog_cmd_q;
   assign cpu_reset    = cpu_reset_q;
   assign load_done    = load_done_q;
   assign load_error   = load_error_q;

endmodule
`default_nettype wire
